// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the datapath operand registers, the
// multiply/divide unit and the HI/LO write-back path.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             zero_exception;

    modport master (
        output start, op, a_in, b_in,
        input  hi_out, lo_out, busy, done, zero_exception
    );

    modport slave (
        input  start, op, a_in, b_in,
        output hi_out, lo_out, busy, done, zero_exception
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, sign-fixed)
// unit, one iteration per clock, results written into HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {IDLE, MCALC, DCALC, FIX, DONE, DZERO} state_t;

    state_t state, next_state;

    logic [2*WIDTH+1:0] prod, prod_step;
    logic [WIDTH:0]     upper, upper_step, b_ext;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   b_reg, rem, quo, rem_step, quo_step;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic [CW-1:0]      count;
    logic               op_reg, neg_q, neg_r, last_iter, accept;
    logic               busy_r, done_r, zexc_r;

    assign last_iter = (count == CW'(ITER - 1));
    // A start coinciding with the done pulse is dropped, not queued.
    assign accept    = bus.start && !done_r;
    assign a_abs     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    assign b_abs     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.op)              next_state = MCALC;
                    else if (bus.b_in == '0)  next_state = DZERO;
                    else                      next_state = DCALC;
                end
            end
            MCALC:   if (last_iter) next_state = DONE;
            DCALC:   if (last_iter) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            DZERO:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The Booth upper half carries one guard bit so -2^(W-1) * -2^(W-1)
    // cannot overflow the accumulator before the shift.
    always_comb begin
        upper = prod[2*WIDTH+1:WIDTH+1];
        b_ext = {b_reg[WIDTH-1], b_reg};
        case (prod[1:0])
            2'b01:   upper_step = upper + b_ext;
            2'b10:   upper_step = upper - b_ext;
            default: upper_step = upper;
        endcase
        prod_step = {upper_step[WIDTH], upper_step, prod[WIDTH:1]};
    end

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, b_reg};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    // For DIV, b_reg holds |b| and quo starts as |a|.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod   <= '0;
            b_reg  <= '0;
            rem    <= '0;
            quo    <= '0;
            count  <= '0;
            op_reg <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg <= bus.op;
                        count  <= '0;
                        prod   <= {{(WIDTH+1){1'b0}}, bus.a_in, 1'b0};
                        b_reg  <= bus.op ? b_abs : bus.b_in;
                        rem    <= '0;
                        quo    <= a_abs;
                        neg_q  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                        neg_r  <= bus.a_in[WIDTH-1];
                    end
                end
                MCALC: begin
                    prod  <= prod_step;
                    count <= count + CW'(1);
                end
                DCALC: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (neg_q) quo <= -quo;
                    if (neg_r) rem <= -rem;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            zexc_r <= 1'b0;
        end else begin
            busy_r <= next_state inside {MCALC, DCALC, FIX, DZERO};
            zexc_r <= (next_state == DZERO);
            done_r <= (state == DONE);
            if (state == DONE) begin
                hi_r <= op_reg ? rem : prod[2*WIDTH:WIDTH+1];
                lo_r <= op_reg ? quo : prod[WIDTH:1];
            end
        end
    end

    assign bus.hi_out         = hi_r;
    assign bus.lo_out         = lo_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.zero_exception = zexc_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic compared against plain signed arithmetic.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Signed / truncates toward zero and % follows the dividend's sign.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
        longint da, db, q, r;
        da = longint'($signed(a));
        db = longint'($signed(b));
        q  = da / db;
        r  = da % db;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                                 input bit poke, input string tag);
        logic [63:0] ref_v;
        bit is_zero;
        int lat, busy_cycles, exc_cycles, done_cycles;
        is_zero = op_v && (b == 32'd0);
        ref_v   = op_v ? (is_zero ? 64'd0 : model_div(a, b)) : model_mul(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = 1'($urandom_range(0, 1));
        bus.a_in    = $urandom;
        bus.b_in    = $urandom;
        busy_cycles = bus.busy ? 1 : 0;
        exc_cycles  = bus.zero_exception ? 1 : 0;
        done_cycles = 0;
        lat         = 0;
        if (is_zero) begin
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                if (bus.zero_exception) exc_cycles++;
                if (bus.done) done_cycles++;
            end
            checkOutput({tag, "_exc_pulse"}, 64'(exc_cycles), 64'd1);
            checkOutput({tag, "_no_done"}, 64'(done_cycles), 64'd0);
            checkOutput({tag, "_hilo_kept"}, {bus.hi_out, bus.lo_out}, {model_hi, model_lo});
            checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
        end else begin
            for (int k = 1; k <= 80; k++) begin
                if (poke && k == 10) begin
                    bus.start = 1'b1;
                    bus.op    = 1'b1;
                    bus.a_in  = 32'd100;
                    bus.b_in  = 32'd10;
                end else if (poke && k == 11) begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                #1;
                if (bus.zero_exception) exc_cycles++;
                if (bus.done) lat = k;
                else if (bus.busy) busy_cycles++;
                if (lat != 0) break;
            end
            checkOutput({tag, "_latency"}, 64'(lat), op_v ? 64'd34 : 64'd33);
            checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), op_v ? 64'd33 : 64'd32);
            checkOutput({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            checkOutput({tag, "_no_exc"}, 64'(exc_cycles), 64'd0);
            checkOutput({tag, "_hi"}, 64'(bus.hi_out), 64'(ref_v[63:32]));
            checkOutput({tag, "_lo"}, 64'(bus.lo_out), 64'(ref_v[31:0]));
            model_hi = ref_v[63:32];
            model_lo = ref_v[31:0];
            // A start raised during the done cycle must be dropped.
            bus.start = 1'b1;
            bus.op    = 1'b0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            checkOutput({tag, "_done_width"}, 64'(bus.done), 64'd0);
            checkOutput({tag, "_start_in_done"}, 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic resetMidDiv();
        int done_cycles;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd1000;
        bus.b_in  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        checkOutput("abort_flags", {61'd0, bus.busy, bus.done, bus.zero_exception}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        done_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cycles++;
        end
        checkOutput("abort_no_done", 64'(done_cycles), 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rop;
        tests_run    = 0;
        tests_failed = 0;
        model_hi     = 32'd0;
        model_lo     = 32'd0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 1'b0;
        bus.a_in     = 32'd0;
        bus.b_in     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        checkOutput("reset_flags", {61'd0, bus.busy, bus.done, bus.zero_exception}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_flags", {61'd0, bus.busy, bus.done, bus.zero_exception}, 64'd0);

        applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult_7x-3");
        applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min_sq");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mult_m1_sq");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_-7/2");
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7/-2");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        applyStimulus(1'b0, 32'd5, 32'd5, 1'b0, "mult_5x5");
        applyStimulus(1'b1, 32'd9, 32'd0, 1'b0, "div_by_zero");
        applyStimulus(1'b0, 32'd12345, 32'hFFFF_FD5A, 1'b1, "mult_poked");

        for (int i = 0; i < 30; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (rop && $urandom_range(0, 7) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($signed(8'($urandom)));
            applyStimulus(rop, ra, rb, 1'b0, rop ? "rand_div" : "rand_mult");
        end

        resetMidDiv();
        applyStimulus(1'b1, 32'd100, 32'd10, 1'b0, "div_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
